// File: rtl/bus_pkg.sv
// bus_pkg: shared constants, FSM states and line levels for the serial frame bus
package bus_pkg;
  localparam int ADDR_W = 4;
  localparam int DATA_W = 64;
  localparam int CRC_W = 4;
  localparam int HDR_BITS = 2 * ADDR_W;
  localparam int FRAME_BITS = 78;
  localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;
  localparam logic IDLE_BIT = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT = 1'b1;
  typedef enum logic [2:0] {IDLE, HDR, DATA, CRCF, STOP, RESYNC} state_t;
endpackage

// File: rtl/bus_frame_receiver_if.sv
// bus_frame_receiver_if: serial line in, decoded frame and status out
interface bus_frame_receiver_if;
  logic bus_in;
  logic [bus_pkg::DATA_W-1:0] data_out;
  logic [bus_pkg::ADDR_W-1:0] src_addr;
  logic [bus_pkg::CRC_W-1:0] crc_out;
  logic valid;
  logic crc_err;
  logic frame_err;
  logic busy;
  modport master(output bus_in, input data_out, src_addr, crc_out, valid, crc_err, frame_err, busy);
  modport slave(input bus_in, output data_out, src_addr, crc_out, valid, crc_err, frame_err, busy);
endinterface

// File: rtl/crc4_serial.sv
// crc4_serial: bit-serial CRC-4 (x^4+x+1), zero init, no final xor
module crc4_serial
  import bus_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);
  logic fb;
  assign fb = bit_in ^ crc[CRC_W-1];
  // clear has priority so a start bit always begins from a zero remainder
  always_ff @(posedge clock or posedge reset)
    if (reset) crc <= '0;
    else if (clr) crc <= '0;
    else if (en) crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
endmodule

// File: rtl/bus_frame_receiver.sv
// bus_frame_receiver: deserializes addressed frames from the serial bus and checks their CRC
module bus_frame_receiver #(
  parameter logic [3:0] MY_ADDR = 4'd1,
  parameter int DATA_W = 64
) (
  input logic clock,
  input logic reset,
  bus_frame_receiver_if.slave bus
);
  import bus_pkg::*;
  state_t state, state_n;
  logic [6:0] cnt;
  logic [HDR_BITS-1:0] hdr;
  logic [DATA_W-1:0] dat;
  logic [CRC_W-1:0] crc_rx, crc_calc;
  logic match, deliver;
  assign bus.busy = state != IDLE;
  // next-state: each field state leaves after its last bit
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = bus.bus_in == START_BIT ? HDR : IDLE;
      HDR:     state_n = cnt == 7'(HDR_BITS - 1) ? DATA : HDR;
      DATA:    state_n = cnt == 7'(DATA_W - 1) ? CRCF : DATA;
      CRCF:    state_n = cnt == 7'(CRC_W - 1) ? STOP : CRCF;
      STOP:    state_n = bus.bus_in == STOP_BIT ? IDLE : RESYNC;
      RESYNC:  state_n = bus.bus_in == IDLE_BIT ? IDLE : RESYNC;
      default: state_n = IDLE;
    endcase
  end
  // state register and per-state bit counter, restarted on every transition
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= state_n != state ? '0 : cnt + 7'd1;
    end
  // field shifters, address match, and outputs delivered the cycle after the stop bit
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      hdr           <= '0;
      dat           <= '0;
      crc_rx        <= '0;
      match         <= 1'b0;
      deliver       <= 1'b0;
      bus.frame_err <= 1'b0;
      bus.valid     <= 1'b0;
      bus.crc_err   <= 1'b0;
      bus.data_out  <= '0;
      bus.src_addr  <= '0;
      bus.crc_out   <= '0;
    end else begin
      if (state == HDR) hdr <= {hdr[HDR_BITS-2:0], bus.bus_in};
      if (state == DATA) dat <= {dat[DATA_W-2:0], bus.bus_in};
      if (state == CRCF) crc_rx <= {crc_rx[CRC_W-2:0], bus.bus_in};
      if (state == HDR && cnt == 7'(HDR_BITS - 1)) match <= {hdr[ADDR_W-2:0], bus.bus_in} == MY_ADDR;
      deliver       <= state == STOP && bus.bus_in == STOP_BIT && match;
      bus.frame_err <= state == STOP && bus.bus_in != STOP_BIT;
      bus.valid     <= deliver;
      if (deliver) begin
        bus.data_out <= dat;
        bus.src_addr <= hdr[HDR_BITS-1:ADDR_W];
        bus.crc_out  <= crc_rx;
        bus.crc_err  <= crc_calc != crc_rx;
      end
    end
  crc4_serial u_crc (
    .clock (clock),
    .reset (reset),
    .clr   (state == IDLE && bus.bus_in == START_BIT),
    .en    (state == HDR || state == DATA),
    .bit_in(bus.bus_in),
    .crc   (crc_calc)
  );
endmodule

// File: tb/tb_bus_frame_receiver.sv
// tb_bus_frame_receiver: scoreboard bench for the serial frame receiver
module tb_bus_frame_receiver;
  typedef struct {
    logic [63:0] d;
    logic [3:0]  s;
    logic [3:0]  c;
    logic        e;
  } exp_t;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  int cyc = 0;
  int n_valid = 0;
  int n_ferr = 0;
  exp_t q[$];
  int vcyc[$];
  bus_frame_receiver_if b();
  bus_frame_receiver #(.MY_ADDR(4'd1), .DATA_W(64)) dut (.clock(clock), .reset(reset), .bus(b));
  always #5 clock = ~clock;
  always @(posedge clock) cyc++;
  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  function automatic logic [3:0] crc_model(input logic [3:0] s, input logic [3:0] d, input logic [63:0] data);
    logic [71:0] v;
    logic [3:0] c;
    v = {s, d, data};
    c = 4'h0;
    for (int i = 71; i >= 0; i--) c = (v[i] ^ c[3]) ? {c[2:0], 1'b0} ^ 4'b0011 : {c[2:0], 1'b0};
    return c;
  endfunction
  task automatic expect_frame(input logic [3:0] s, input logic [63:0] data, input logic [3:0] c);
    exp_t e;
    e.d = data;
    e.s = s;
    e.c = c;
    e.e = c != crc_model(s, 4'd1, data);
    q.push_back(e);
  endtask
  task automatic send(input logic [3:0] s, input logic [3:0] d, input logic [63:0] data, input logic [3:0] c, input logic stop, input int nbits);
    logic [77:0] f;
    f = {1'b0, s, d, data, c, stop};
    for (int i = 77; i > 77 - nbits; i--) begin
      @(negedge clock);
      b.bus_in = f[i];
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      b.bus_in = 1'b1;
    end
  endtask
  always @(negedge clock)
    if (!reset) begin
      if (b.valid) begin
        n_valid++;
        vcyc.push_back(cyc);
        if (q.size() == 0) chk("unexpected_valid", 1, 0);
        else begin
          exp_t e;
          e = q.pop_front();
          chk("data_out", b.data_out, e.d);
          chk("src_addr", 64'(b.src_addr), 64'(e.s));
          chk("crc_out", 64'(b.crc_out), 64'(e.c));
          chk("crc_err", 64'(b.crc_err), 64'(e.e));
        end
      end
      if (b.frame_err) n_ferr++;
    end
  initial begin
    b.bus_in = 1'b1;
    repeat (3) @(negedge clock);
    chk("rst_valid", 64'(b.valid), 0);
    chk("rst_data", b.data_out, 0);
    chk("rst_busy", 64'(b.busy), 0);
    chk("rst_ferr", 64'(b.frame_err), 0);
    reset = 1'b0;
    idle(2);
    chk("idle_busy", 64'(b.busy), 0);
    expect_frame(4'd1, 64'h1, 4'h9);
    send(4'd1, 4'd1, 64'h1, 4'h9, 1'b1, 78);
    idle(4);
    expect_frame(4'd1, 64'h1, 4'h1);
    send(4'd1, 4'd1, 64'h1, 4'h1, 1'b1, 78);
    idle(4);
    send(4'd3, 4'd2, 64'h1234_5678_9ABC_DEF0, crc_model(4'd3, 4'd2, 64'h1234_5678_9ABC_DEF0), 1'b1, 78);
    @(negedge clock);
    b.bus_in = 1'b1;
    chk("mismatch_busy", 64'(b.busy), 0);
    idle(3);
    chk("mismatch_data_hold", b.data_out, 64'h1);
    chk("mismatch_src_hold", 64'(b.src_addr), 64'd1);
    chk("mismatch_crc_hold", 64'(b.crc_out), 64'h1);
    expect_frame(4'd5, 64'hCAFE_F00D_0000_0001, crc_model(4'd5, 4'd1, 64'hCAFE_F00D_0000_0001));
    send(4'd5, 4'd1, 64'hCAFE_F00D_0000_0001, crc_model(4'd5, 4'd1, 64'hCAFE_F00D_0000_0001), 1'b1, 78);
    expect_frame(4'd7, 64'hDEADBEEF_00000000, crc_model(4'd7, 4'd1, 64'hDEADBEEF_00000000));
    send(4'd7, 4'd1, 64'hDEADBEEF_00000000, crc_model(4'd7, 4'd1, 64'hDEADBEEF_00000000), 1'b1, 78);
    idle(4);
    chk("b2b_spacing", 64'(vcyc[vcyc.size()-1] - vcyc[vcyc.size()-2]), 64'd78);
    send(4'd1, 4'd1, 64'h55, 4'h0, 1'b0, 78);
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      b.bus_in = 1'b0;
      chk("resync_busy", 64'(b.busy), 1);
    end
    chk("frame_err_count", 64'(n_ferr), 1);
    @(negedge clock);
    b.bus_in = 1'b1;
    @(negedge clock);
    chk("resync_exit_busy", 64'(b.busy), 0);
    idle(2);
    send(4'd9, 4'd1, 64'hFFFF_0000_FFFF_0000, 4'h3, 1'b1, 40);
    @(negedge clock);
    reset = 1'b1;
    #1;
    chk("midrst_busy", 64'(b.busy), 0);
    chk("midrst_data", b.data_out, 0);
    chk("midrst_src", 64'(b.src_addr), 0);
    chk("midrst_crc", 64'(b.crc_out), 0);
    chk("midrst_valid", 64'(b.valid), 0);
    @(negedge clock);
    reset = 1'b0;
    b.bus_in = 1'b1;
    idle(2);
    expect_frame(4'd1, 64'h1, 4'h9);
    send(4'd1, 4'd1, 64'h1, 4'h9, 1'b1, 78);
    idle(5);
    chk("scoreboard_empty", 64'(q.size()), 0);
    chk("valid_count", 64'(n_valid), 5);
    chk("frame_err_total", 64'(n_ferr), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
